// File: rtl/axis_data_gen.sv
// ----------------------------------------------------------------------------
// axis_data_gen
//   Free-running 32-bit test-pattern source for streaming datapaths. Emits one
//   word per clock while en is high and pauses, holding its sequence position,
//   while en is low. There is no backpressure input, so every VALID cycle is
//   one consumed word.
//
// Parameters
//   MODE        : 0 = incrementing counter, 1 = 32-bit Galois LFSR
//   START_VALUE : first counter word after reset (MODE 0)
//   INCREMENT   : counter step (MODE 0)
//   LFSR_SEED   : first LFSR word after reset (MODE 1); 0 is replaced by 1
//
// Ports
//   ACLK   in   1   rising-edge clock
//   RSTN   in   1   synchronous reset, active-high (asserted when 1)
//   en     in   1   generate enable, sampled every rising edge
//   TDATA  out  32  generated word, registered
//   VALID  out  1   TDATA holds a new word this cycle, registered
// ----------------------------------------------------------------------------
module axis_data_gen #(
    parameter int          MODE        = 0,
    parameter logic [31:0] START_VALUE = 32'h0000_0000,
    parameter logic [31:0] INCREMENT   = 32'h0000_0001,
    parameter logic [31:0] LFSR_SEED   = 32'h0000_0001
) (
    input  logic        ACLK,
    input  logic        RSTN,
    input  logic        en,
    output logic [31:0] TDATA,
    output logic        VALID
);

    // Taps for x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] EFF_SEED  = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;
    localparam logic [31:0] INIT_WORD = (MODE == 1) ? EFF_SEED : START_VALUE;

    logic [31:0] nxt;
    logic [31:0] nxt_step;

    always_comb begin
        nxt_step = nxt + INCREMENT;
        if (MODE == 1) begin
            if (nxt[0]) begin
                nxt_step = (nxt >> 1) ^ LFSR_TAPS;
            end else begin
                nxt_step = nxt >> 1;
            end
        end
    end

    // Reset wins over en; with en low TDATA and nxt simply hold so the
    // sequence resumes exactly where it stopped.
    always_ff @(posedge ACLK) begin
        if (RSTN) begin
            nxt   <= INIT_WORD;
            TDATA <= 32'h0;
            VALID <= 1'b0;
        end else if (en) begin
            TDATA <= nxt;
            VALID <= 1'b1;
            nxt   <= nxt_step;
        end else begin
            VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_data_gen.sv
// ----------------------------------------------------------------------------
// tb_axis_data_gen
//   Directed bench for axis_data_gen. Four instances share clock, reset and
//   enable: default counter, counter starting near wrap, LFSR seed 1 and
//   LFSR seed 0. Expected words are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_axis_data_gen;

    logic        ACLK;
    logic        RSTN;
    logic        en;

    logic [31:0] tdata_def,  tdata_wrap,  tdata_l1,  tdata_l0;
    logic        valid_def,  valid_wrap,  valid_l1,  valid_l0;

    int n_checks = 0;
    int n_errors = 0;

    axis_data_gen u_def (
        .ACLK (ACLK), .RSTN (RSTN), .en (en),
        .TDATA(tdata_def), .VALID(valid_def)
    );

    axis_data_gen #(.START_VALUE(32'hFFFF_FFFE), .INCREMENT(32'h1)) u_wrap (
        .ACLK (ACLK), .RSTN (RSTN), .en (en),
        .TDATA(tdata_wrap), .VALID(valid_wrap)
    );

    axis_data_gen #(.MODE(1), .LFSR_SEED(32'h1)) u_lfsr1 (
        .ACLK (ACLK), .RSTN (RSTN), .en (en),
        .TDATA(tdata_l1), .VALID(valid_l1)
    );

    axis_data_gen #(.MODE(1), .LFSR_SEED(32'h0)) u_lfsr0 (
        .ACLK (ACLK), .RSTN (RSTN), .en (en),
        .TDATA(tdata_l0), .VALID(valid_l0)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One rising edge with the given inputs; outputs are sampled 1 ns later.
    task automatic step(input logic rst_v, input logic en_v);
        RSTN = rst_v;
        en   = en_v;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'b0);
        check_val("rst_valid", {31'h0, valid_def}, 32'h0);
        check_val("rst_tdata", tdata_def, 32'h0);
    endtask

    // LFSR seed 1: 1 -> 0x8020_0003 -> (0x4010_0001 ^ 0x8020_0003) = 0xC030_0002
    logic [31:0] lfsr_exp [3];
    logic [31:0] wrap_exp [4];
    logic        pat_en   [5];
    logic        pat_vld  [5];
    logic [31:0] pat_dat  [5];

    initial begin
        lfsr_exp = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        pat_en   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        pat_vld  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        pat_dat  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2};

        RSTN = 1'b1;
        en   = 1'b0;
        #2;

        // Reset, then 10-word burst, then idle with TDATA held.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            check_val("burst10_valid", {31'h0, valid_def}, 32'h1);
            check_val("burst10_tdata", tdata_def, i);
        end
        step(1'b0, 1'b0);
        check_val("burst10_end_valid", {31'h0, valid_def}, 32'h0);
        check_val("burst10_end_tdata", tdata_def, 32'd9);

        // 2-cycle reset pulse, then burst of 5 restarts at 0.
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            check_val("burst5_valid", {31'h0, valid_def}, 32'h1);
            check_val("burst5_tdata", tdata_def, i);
        end

        // en pattern 1,1,0,0,1.
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, pat_en[i]);
            check_val("pause_valid", {31'h0, valid_def}, {31'h0, pat_vld[i]});
            check_val("pause_tdata", tdata_def, pat_dat[i]);
        end

        // Reset coincident with en mid-burst.
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check_val("pre_clash_tdata", tdata_def, 32'd2);
        step(1'b1, 1'b1);
        check_val("clash_valid", {31'h0, valid_def}, 32'h0);
        check_val("clash_tdata", tdata_def, 32'h0);
        step(1'b0, 1'b1);
        check_val("after_clash_valid", {31'h0, valid_def}, 32'h1);
        check_val("after_clash_tdata", tdata_def, 32'h0);

        // Counter wrap and LFSR sequences (seed 1 and seed 0 must match).
        do_reset(1);
        check_val("wrap_rst_tdata", tdata_wrap, 32'h0);
        check_val("lfsr_rst_valid", {31'h0, valid_l1}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check_val("wrap_valid", {31'h0, valid_wrap}, 32'h1);
            check_val("wrap_tdata", tdata_wrap, wrap_exp[i]);
            if (i < 3) begin
                check_val("lfsr_s1_tdata", tdata_l1, lfsr_exp[i]);
                check_val("lfsr_s0_tdata", tdata_l0, lfsr_exp[i]);
                check_val("lfsr_s0_valid", {31'h0, valid_l0}, 32'h1);
            end
        end
        step(1'b0, 1'b0);
        check_val("wrap_idle_valid", {31'h0, valid_wrap}, 32'h0);
        check_val("wrap_idle_tdata", tdata_wrap, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
